// File: rtl/mem_stage.sv
// Memory-access stage with multi-cycle data memory and the MEM/WB pipeline register.
// Optional macro MEM_FWD_EN adds the MEM/WB forwarding outputs (Fwd_Valid/Fwd_Dst/Fwd_Val).
module mem_stage #(
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 2
) (
  input  logic        Clk,
  input  logic        rst,
  input  logic        WB_Enable,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [9:0]  PC,
  input  logic [15:0] ALU_Result,
  input  logic [15:0] ST_Value,
  input  logic [3:0]  DstReg,
  output logic        Stall,
  output logic        WBEnableOut,
  output logic        MemReadOut,
  output logic [9:0]  PCOut,
  output logic [15:0] ALU_ResultOut,
  output logic [15:0] MemDataOut,
  output logic [3:0]  DstRegOut,
  output logic [15:0] WB_Value
`ifdef MEM_FWD_EN
  ,
  output logic        Fwd_Valid,
  output logic [3:0]  Fwd_Dst,
  output logic [15:0] Fwd_Val
`endif
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t            state_r, state_nxt;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt;
  logic              stall_s, capture_s, bubble_s;
  logic              access_s, load_s;
  logic [ADDR_W-1:0] addr_s;
  logic [15:0]       rd_data_s;
  logic [15:0]       mem_r [0:(1<<ADDR_W)-1];
  logic              unused_addr_s;

  // Upper address bits are discarded so addresses wrap around the array.
  assign addr_s        = ALU_Result[ADDR_W-1:0];
  assign unused_addr_s = ^ALU_Result[15:ADDR_W];
  assign access_s      = MemRead | MemWrite;
  assign load_s        = MemRead & ~MemWrite;
  assign rd_data_s     = load_s ? mem_r[addr_s] : 16'h0000;

  // Next-state, stall and capture/bubble decode.
  always_comb begin
    state_nxt = state_r;
    cnt_nxt   = cnt_r;
    stall_s   = 1'b0;
    capture_s = 1'b0;
    bubble_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (access_s && (MEM_LAT > 1)) begin
          stall_s   = 1'b1;
          bubble_s  = 1'b1;
          state_nxt = BUSY;
          cnt_nxt   = CNT_W'(1);
        end else begin
          capture_s = 1'b1;
        end
      end
      BUSY: begin
        if (cnt_r == CNT_LAST) begin
          capture_s = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = {CNT_W{1'b0}};
        end else begin
          stall_s  = 1'b1;
          bubble_s = 1'b1;
          cnt_nxt  = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = {CNT_W{1'b0}};
      end
    endcase
  end

  assign Stall = rst ? 1'b0 : stall_s;

  // FSM state and latency counter.
  always_ff @(posedge Clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt;
      cnt_r   <= cnt_nxt;
    end
  end

  // Store commits only on the completing edge; reset aborts a pending store.
  always_ff @(posedge Clk) begin
    if (!rst && capture_s && MemWrite) begin
      mem_r[addr_s] <= ST_Value;
    end
  end

  // MEM/WB pipeline register; bubbles are all-zero.
  always_ff @(posedge Clk) begin
    if (rst || bubble_s) begin
      WBEnableOut   <= 1'b0;
      MemReadOut    <= 1'b0;
      PCOut         <= 10'h000;
      ALU_ResultOut <= 16'h0000;
      MemDataOut    <= 16'h0000;
      DstRegOut     <= 4'h0;
    end else if (capture_s) begin
      WBEnableOut   <= WB_Enable;
      MemReadOut    <= load_s;
      PCOut         <= PC;
      ALU_ResultOut <= ALU_Result;
      MemDataOut    <= rd_data_s;
      DstRegOut     <= DstReg;
    end
  end

  assign WB_Value = MemReadOut ? MemDataOut : ALU_ResultOut;

`ifdef MEM_FWD_EN
  assign Fwd_Valid = WBEnableOut & (DstRegOut != 4'h0);
  assign Fwd_Dst   = DstRegOut;
  assign Fwd_Val   = WB_Value;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; instances with MEM_LAT = 1, 2, 4 share stimulus.
module tb_mem_stage;
  logic        clk, rst;
  logic        wb_en, mem_rd, mem_wr;
  logic [9:0]  pc;
  logic [15:0] alu, st_val;
  logic [3:0]  dst;

  logic [2:0]  stall, wbo, mro;
  logic [9:0]  pco   [3];
  logic [15:0] aluo  [3];
  logic [15:0] mdo   [3];
  logic [3:0]  dsto  [3];
  logic [15:0] wbv   [3];
`ifdef MEM_FWD_EN
  logic [2:0]  fvalid;
  logic [3:0]  fdst  [3];
  logic [15:0] fval  [3];
`endif

  int total_cnt = 0;
  int bad_cnt   = 0;
  int n1, n4;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_stage #(.ADDR_W(8), .MEM_LAT((g == 0) ? 1 : (g == 1) ? 2 : 4)) u_dut (
      .Clk(clk), .rst(rst), .WB_Enable(wb_en), .MemRead(mem_rd), .MemWrite(mem_wr),
      .PC(pc), .ALU_Result(alu), .ST_Value(st_val), .DstReg(dst),
      .Stall(stall[g]), .WBEnableOut(wbo[g]), .MemReadOut(mro[g]), .PCOut(pco[g]),
      .ALU_ResultOut(aluo[g]), .MemDataOut(mdo[g]), .DstRegOut(dsto[g]), .WB_Value(wbv[g])
`ifdef MEM_FWD_EN
      , .Fwd_Valid(fvalid[g]), .Fwd_Dst(fdst[g]), .Fwd_Val(fval[g])
`endif
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic req(input logic w, input logic r, input logic s, input logic [9:0] p,
                     input logic [15:0] a, input logic [15:0] v, input logic [3:0] d);
    wb_en = w; mem_rd = r; mem_wr = s; pc = p; alu = a; st_val = v; dst = d;
  endtask

  initial begin
    // Reset: stall suppressed even with a load pending.
    rst = 1'b1;
    req(1'b0, 1'b1, 1'b0, 10'h000, 16'h0000, 16'h0000, 4'h0);
    tick(); tick();
    chk("rst_stall", 16'(stall), 16'h0000);
    chk("rst_wbo", 16'(wbo[1]), 16'h0000);
    chk("rst_alu", aluo[1], 16'h0000);
    chk("rst_md", mdo[1], 16'h0000);
    rst = 1'b0;
    req(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000, 16'h0000, 4'h0);
    tick();

    // ALU passthrough, latency 1, no stall
    req(1'b1, 1'b0, 1'b0, 10'h003, 16'h1234, 16'h0000, 4'h5);
    #1 chk("pass_stall", 16'(stall[1]), 16'h0000);
    tick();
    chk("pass_wbo", 16'(wbo[1]), 16'h0001);
    chk("pass_alu", aluo[1], 16'h1234);
    chk("pass_dst", 16'(dsto[1]), 16'h0005);
    chk("pass_pc", 16'(pco[1]), 16'h0003);
    chk("pass_wbv", wbv[1], 16'h1234);

    // Store 0xBEEF to 0x10
    req(1'b0, 1'b0, 1'b1, 10'h004, 16'h0010, 16'hBEEF, 4'h0);
    #1 chk("st_stall0", 16'(stall[1]), 16'h0001);
    tick();
    chk("st_stall1", 16'(stall[1]), 16'h0000);
    chk("st_bubble", aluo[1], 16'h0000);
    tick();
    chk("st_done_alu", aluo[1], 16'h0010);
    chk("st_done_wbo", 16'(wbo[1]), 16'h0000);

    // Load back from 0x10
    req(1'b1, 1'b1, 1'b0, 10'h005, 16'h0010, 16'h0000, 4'h3);
    #1 chk("ld_stall0", 16'(stall[1]), 16'h0001);
    tick();
    chk("ld_stall1", 16'(stall[1]), 16'h0000);
    chk("ld_bubble_wbo", 16'(wbo[1]), 16'h0000);
    tick();
    chk("ld_md", mdo[1], 16'hBEEF);
    chk("ld_wbv", wbv[1], 16'hBEEF);
    chk("ld_dst", 16'(dsto[1]), 16'h0003);
    chk("ld_mro", 16'(mro[1]), 16'h0001);
    chk("ld_wbo", 16'(wbo[1]), 16'h0001);

    // Read+write together behaves as a store
    req(1'b1, 1'b1, 1'b1, 10'h006, 16'h0011, 16'h5A5A, 4'h2);
    tick(); tick();
    chk("both_mro", 16'(mro[1]), 16'h0000);
    chk("both_md", mdo[1], 16'h0000);
    chk("both_wbv", wbv[1], 16'h0011);
    req(1'b1, 1'b1, 1'b0, 10'h007, 16'h0011, 16'h0000, 4'h2);
    tick(); tick();
    chk("both_rd", mdo[1], 16'h5A5A);

    // Address wrap: 0x0105 aliases 0x0005
    req(1'b0, 1'b0, 1'b1, 10'h008, 16'h0105, 16'hCAFE, 4'h0);
    tick(); tick();
    req(1'b1, 1'b1, 1'b0, 10'h009, 16'h0005, 16'h0000, 4'h6);
    tick(); tick();
    chk("wrap_wbv", wbv[1], 16'hCAFE);

    // Mid-run reset during BUSY
    req(1'b1, 1'b1, 1'b0, 10'h00A, 16'h0005, 16'h0000, 4'h6);
    tick();
    rst = 1'b1;
    #1 chk("mrst_stall", 16'(stall[1]), 16'h0000);
    tick(); tick();
    chk("mrst_wbo", 16'(wbo[1]), 16'h0000);
    chk("mrst_pc", 16'(pco[1]), 16'h0000);
    chk("mrst_dst", 16'(dsto[1]), 16'h0000);
    chk("mrst_wbv", wbv[1], 16'h0000);
    rst = 1'b0;
    #1 chk("mrst_idle_stall", 16'(stall[1]), 16'h0001);
    tick(); tick();
    chk("mrst_reload", mdo[1], 16'hCAFE);

    // Latency sweep: MEM_LAT 1 and 4
    rst = 1'b1;
    req(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000, 16'h0000, 4'h0);
    tick();
    rst = 1'b0;
    req(1'b0, 1'b0, 1'b1, 10'h00B, 16'h0030, 16'h7777, 4'h0);
    repeat (4) tick();
    req(1'b1, 1'b1, 1'b0, 10'h00C, 16'h0030, 16'h0000, 4'h9);
    n1 = 0;
    n4 = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (stall[0]) n1++;
      if (stall[2]) n4++;
      tick();
      if (i == 0) chk("lat1_md", mdo[0], 16'h7777);
      if (i == 2) chk("lat4_bubble", mdo[2], 16'h0000);
    end
    chk("lat4_md", mdo[2], 16'h7777);
    chk("lat4_wbo", 16'(wbo[2]), 16'h0001);
    chk("lat1_stalls", 16'(n1), 16'h0000);
    chk("lat4_stalls", 16'(n4), 16'h0003);

    // Abort a MEM_LAT=4 store in its 2nd cycle
    rst = 1'b1;
    req(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000, 16'h0000, 4'h0);
    tick();
    rst = 1'b0;
    req(1'b0, 1'b0, 1'b1, 10'h00D, 16'h0020, 16'h1111, 4'h0);
    repeat (4) tick();
    req(1'b0, 1'b0, 1'b1, 10'h00E, 16'h0020, 16'h2222, 4'h0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000, 16'h0000, 4'h0);
    tick();
    req(1'b1, 1'b1, 1'b0, 10'h00F, 16'h0020, 16'h0000, 4'h1);
    repeat (4) tick();
    chk("abort_lat4", mdo[2], 16'h1111);
    chk("abort_lat2", mdo[1], 16'h1111);
    chk("abort_lat1_committed", mdo[0], 16'h2222);

`ifdef MEM_FWD_EN
    req(1'b0, 1'b0, 1'b1, 10'h010, 16'h0040, 16'h00AA, 4'h0);
    tick(); tick();
    req(1'b1, 1'b1, 1'b0, 10'h011, 16'h0040, 16'h0000, 4'h7);
    tick(); tick();
    chk("fwd_valid", 16'(fvalid[1]), 16'h0001);
    chk("fwd_dst", 16'(fdst[1]), 16'h0007);
    chk("fwd_val", fval[1], 16'h00AA);
    req(1'b1, 1'b0, 1'b0, 10'h012, 16'h0055, 16'h0000, 4'h0);
    tick();
    chk("fwd_r0", 16'(fvalid[1]), 16'h0000);
`endif

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end
endmodule
